// File: rtl/lfsr_7_check_rx_pkg.sv
// Shared constants for the 411-bit, 12-bit-per-cycle LFSR remainder generator/checker pair.
package lfsr_7_check_rx_pkg;

    localparam int unsigned WIDTH     = 411;
    localparam int unsigned W         = 12;
    localparam int unsigned CHKW      = (WIDTH + W - 1) / W;
    localparam int unsigned LAST_BITS = WIDTH - (CHKW - 1) * W;
    localparam int unsigned CNT_W     = 6;

    localparam int unsigned TAP_A = 31;
    localparam int unsigned TAP_B = 60;
    localparam int unsigned TAP_C = 190;
    localparam int unsigned TAP_D = 195;
    localparam int unsigned TAP_E = 245;

    localparam logic [WIDTH-1:0] SEED = '0;

    // Feedback positions other than bit 0, which always takes msb^data.
    function automatic logic [WIDTH-1:0] tap_mask();
        logic [WIDTH-1:0] m;
        m        = '0;
        m[TAP_A] = 1'b1;
        m[TAP_B] = 1'b1;
        m[TAP_C] = 1'b1;
        m[TAP_D] = 1'b1;
        m[TAP_E] = 1'b1;
        return m;
    endfunction

    localparam logic [WIDTH-1:0] TAP_MASK  = tap_mask();
    localparam logic [W-1:0]     LAST_MASK = W'((1 << LAST_BITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/lfsr_7_step12.sv
// Combinational 12-step LFSR next-state function; data bit 0 is shifted in first.
module lfsr_7_step12
    import lfsr_7_check_rx_pkg::*;
(
    input  logic [WIDTH-1:0] state_in,
    input  logic [W-1:0]     data,
    output logic [WIDTH-1:0] state_out
);

    logic [WIDTH-1:0] w_s;
    logic             w_msb;

    always_comb begin
        w_s   = state_in;
        w_msb = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            w_msb = w_s[WIDTH-1];
            w_s   = {w_s[WIDTH-2:0], w_msb ^ data[i]} ^ (TAP_MASK & {WIDTH{w_msb}});
        end
        state_out = w_s;
    end

endmodule

// File: rtl/lfsr_7_check_rx.sv
// Receive-side LFSR remainder checker: recomputes the remainder over payload words and
// compares it against the 35 trailing check words, reporting pass/fail once per frame.
module lfsr_7_check_rx
    import lfsr_7_check_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_sof,
    input  logic             in_last,
    output logic             done,
    output logic             pass,
    output logic             err_frame,
    output logic [WIDTH-1:0] rem_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHKW - 1);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_lfsr, w_lfsr_nxt;
    logic [CNT_W-1:0]   r_chk_cnt, w_chk_cnt_nxt;
    logic               r_mismatch, w_mismatch_nxt;
    logic               r_err_frame, w_err_frame_nxt;

    logic               w_xfer;
    logic [WIDTH-1:0]   w_step_in;
    logic [WIDTH-1:0]   w_step_out;
    logic [CHKW*W-1:0]  w_pad;
    logic [W-1:0]       w_words [CHKW];
    logic [W-1:0]       w_slice;
    logic [W-1:0]       w_mask;
    logic               w_miss;

    assign w_xfer = in_valid & in_ready;

    // A sof word always restarts from SEED, including the abort-and-restart case in PAYLOAD.
    assign w_step_in = ((r_state == S_IDLE) || in_sof) ? SEED : r_lfsr;

    lfsr_7_step12 u_step (
        .state_in  (w_step_in),
        .data      (in_data),
        .state_out (w_step_out)
    );

    // Zero-pad so the final partial check word indexes like the others.
    assign w_pad = {{(CHKW*W-WIDTH){1'b0}}, r_lfsr};

    always_comb begin
        for (int unsigned k = 0; k < CHKW; k++) begin
            w_words[k] = w_pad[k*W +: W];
        end
    end

    assign w_slice = w_words[r_chk_cnt];
    assign w_mask  = (r_chk_cnt == LAST_CNT) ? LAST_MASK : '1;
    assign w_miss  = |((in_data ^ w_slice) & w_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED;
            r_chk_cnt   <= '0;
            r_mismatch  <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_chk_cnt   <= w_chk_cnt_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_err_frame <= w_err_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_chk_cnt_nxt   = r_chk_cnt;
        w_mismatch_nxt  = r_mismatch;
        w_err_frame_nxt = r_err_frame;

        unique case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (in_sof) begin
                        w_lfsr_nxt      = w_step_out;
                        w_mismatch_nxt  = 1'b0;
                        w_err_frame_nxt = 1'b0;
                        w_chk_cnt_nxt   = '0;
                        w_state_nxt     = in_last ? S_CHECK : S_PAYLOAD;
                    end else begin
                        w_err_frame_nxt = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_xfer) begin
                    w_lfsr_nxt = w_step_out;
                    if (in_sof) begin
                        w_mismatch_nxt  = 1'b0;
                        w_err_frame_nxt = 1'b1;
                    end
                    if (in_last) begin
                        w_chk_cnt_nxt = '0;
                        w_state_nxt   = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_xfer) begin
                    if (in_sof || in_last) begin
                        w_err_frame_nxt = 1'b1;
                    end
                    if (w_miss) begin
                        w_mismatch_nxt = 1'b1;
                    end
                    if (r_chk_cnt == LAST_CNT) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_chk_cnt_nxt = r_chk_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign pass      = done & ~r_mismatch;
    assign err_frame = r_err_frame;
    assign rem_out   = r_lfsr;

endmodule

// File: tb/tb_lfsr_7_check_rx.sv
// Directed bench for lfsr_7_check_rx with an independent bit-serial remainder model.
module tb_lfsr_7_check_rx;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [11:0]  in_data = '0;
    logic         in_sof = 1'b0;
    logic         in_last = 1'b0;
    logic         done;
    logic         pass;
    logic         err_frame;
    logic [410:0] rem_out;

    int  n_vec = 0;
    int  n_err = 0;
    int  dcnt  = 0;
    bit  gaps  = 1'b0;
    bit  rdy_chk = 1'b0;
    logic [11:0] payload [64];

    lfsr_7_check_rx u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_last   (in_last),
        .done      (done),
        .pass      (pass),
        .err_frame (err_frame),
        .rem_out   (rem_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (done === 1'b1) dcnt++;

    always @(negedge clk) begin
        if (rdy_chk && rst) check("ready_vs_done", {31'b0, in_ready}, {31'b0, ~done});
    end

    // Bit-serial reference: shift up, bit 0 takes msb^data, listed taps xor in msb.
    function automatic logic [410:0] m_step(input logic [410:0] r, input logic [11:0] d);
        logic [410:0] n;
        logic         msb;
        for (int b = 0; b < 12; b++) begin
            msb = r[410];
            for (int k = 410; k >= 1; k--) begin
                n[k] = r[k-1];
                if (k == 31 || k == 60 || k == 190 || k == 195 || k == 245) n[k] = n[k] ^ msb;
            end
            n[0] = msb ^ d[b];
            r = n;
        end
        return r;
    endfunction

    task automatic send(input logic [11:0] d, input bit sof, input bit last);
        int wait_n;
        int g;
        g = 0;
        if (gaps) begin
            while (g < 4 && $urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                g++;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_last  = last;
        wait_n   = 0;
        while (!in_ready && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int flip_k, input logic [11:0] flip_m,
                              input bit junk, input bit exp_pass, input bit exp_err,
                              input string tag);
        logic [410:0] r;
        logic [419:0] pad;
        logic [11:0]  w;
        int           d0;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = m_step(r, payload[i]);
            send(payload[i], i == 0, i == n - 1);
        end
        check({tag, "_rem"}, {31'b0, rem_out === r}, 32'd1);
        pad = {9'b0, r};
        d0  = dcnt;
        for (int k = 0; k < 35; k++) begin
            w = pad[k*12 +: 12];
            if (k == flip_k) w = w ^ flip_m;
            if (k == 34 && junk) w[11:3] = 9'h1FF;
            send(w, 1'b0, 1'b0);
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_pass"}, {31'b0, pass}, {31'b0, exp_pass});
        check({tag, "_err"},  {31'b0, err_frame}, {31'b0, exp_err});
        @(posedge clk); #1;
        check({tag, "_done_once"}, dcnt - d0, 32'd1);
        check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [410:0] r;
        logic [419:0] pad;
        int           d0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_pass",  {31'b0, pass}, 32'd0);
        check("rst_err",   {31'b0, err_frame}, 32'd0);
        check("rst_rem",   {31'b0, |rem_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: one word 0x001 from zero seed leaves only bit 11 set.
        send(12'h001, 1'b1, 1'b1);
        check("t1_rem_lo", rem_out[31:0], 32'h0000_0800);
        check("t1_rem_hi", {31'b0, |rem_out[410:32]}, 32'd0);
        d0 = dcnt;
        send(12'h800, 1'b0, 1'b0);
        for (int k = 1; k < 35; k++) send(12'h000, 1'b0, 1'b0);
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_pass", {31'b0, pass}, 32'd1);
        check("t1_err",  {31'b0, err_frame}, 32'd0);
        check("t1_ready_done", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("t1_done_once", dcnt - d0, 32'd1);
        check("t1_pass_low", {31'b0, pass}, 32'd0);

        // 2: 20-word frame, clean then with one check bit flipped.
        for (int i = 0; i < 20; i++) payload[i] = 12'($urandom);
        send_frame(20, -1, 12'h000, 1'b0, 1'b1, 1'b0, "t2_good");
        send_frame(20, 17, 12'h020, 1'b0, 1'b0, 1'b0, "t2_flip");

        // 3: stray word in IDLE is dropped and flagged; next sof clears the flag.
        d0 = dcnt;
        send(12'h5A5, 1'b0, 1'b0);
        check("t3_err_set", {31'b0, err_frame}, 32'd1);
        @(posedge clk); #1;
        check("t3_no_done", dcnt - d0, 32'd0);
        for (int i = 0; i < 7; i++) payload[i] = 12'($urandom);
        send_frame(7, -1, 12'h000, 1'b0, 1'b1, 1'b0, "t3");

        // 4: sof after 5 payload words aborts and restarts; err stays set.
        d0 = dcnt;
        for (int i = 0; i < 5; i++) send(12'($urandom), i == 0, 1'b0);
        check("t4_no_done", dcnt - d0, 32'd0);
        for (int i = 0; i < 9; i++) payload[i] = 12'($urandom);
        send_frame(9, -1, 12'h000, 1'b0, 1'b1, 1'b1, "t4");

        // 5: junk in unused bits of final check word, then the same with valid gaps.
        for (int i = 0; i < 11; i++) payload[i] = 12'($urandom);
        send_frame(11, -1, 12'h000, 1'b1, 1'b1, 1'b0, "t5");
        gaps    = 1'b1;
        rdy_chk = 1'b1;
        send_frame(11, -1, 12'h000, 1'b1, 1'b1, 1'b0, "t5_gaps");
        gaps    = 1'b0;
        rdy_chk = 1'b0;

        // 6: reset while check word 10 is presented.
        for (int i = 0; i < 8; i++) payload[i] = 12'($urandom);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r = m_step(r, payload[i]);
            send(payload[i], i == 0, i == 7);
        end
        pad = {9'b0, r};
        for (int k = 0; k < 10; k++) send(pad[k*12 +: 12], 1'b0, k == 9);
        check("t6_err_before", {31'b0, err_frame}, 32'd1);
        d0 = dcnt;
        in_valid = 1'b1;
        in_data  = pad[120 +: 12];
        rst      = 1'b0;
        #1;
        check("t6_rst_ready", {31'b0, in_ready}, 32'd1);
        check("t6_rst_done",  {31'b0, done}, 32'd0);
        check("t6_rst_pass",  {31'b0, pass}, 32'd0);
        check("t6_rst_err",   {31'b0, err_frame}, 32'd0);
        check("t6_rst_rem",   {31'b0, |rem_out}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", dcnt - d0, 32'd0);
        send_frame(8, -1, 12'h000, 1'b0, 1'b1, 1'b0, "t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
